// File: rtl/ctrl_pkt_gen.sv
// Control-packet generator and AXI-Stream merger ahead of pkt_filter.
// Define CTRL_IP_CSUM_EN to emit a real IPv4 header checksum.
module ctrl_pkt_gen #(
    parameter int          C_S_AXIS_DATA_WIDTH  = 512,
    parameter int          C_S_AXIS_TUSER_WIDTH = 128,
    parameter logic [15:0] CTRL_UDP_PORT        = 16'hf1f2,
    parameter logic [47:0] SRC_MAC              = 48'h0,
    parameter logic [47:0] DST_MAC              = 48'h0,
    parameter logic [31:0] SRC_IP               = 32'h0a000001,
    parameter logic [31:0] DST_IP               = 32'h0a000002
) (
    input  logic                              clk,
    input  logic                              srst,
    input  logic                              cfg_valid,
    output logic                              cfg_ready,
    input  logic [11:0]                       cfg_module_id,
    input  logic [3:0]                        cfg_resv,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    cfg_data,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tlast,
    output logic                              s_axis_tready,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready
);

    typedef enum logic [1:0] {IDLE, DATA, CTL0, CTL1} state_t;

`ifdef CTRL_IP_CSUM_EN
    localparam logic [31:0] CS_SUM = 32'h4500 + 32'h0072 + 32'h4011
        + {16'h0, SRC_IP[31:16]} + {16'h0, SRC_IP[15:0]}
        + {16'h0, DST_IP[31:16]} + {16'h0, DST_IP[15:0]};
    localparam logic [31:0] CS_F1 =
        {16'h0, CS_SUM[31:16]} + {16'h0, CS_SUM[15:0]};
    localparam logic [31:0] CS_F2 =
        {16'h0, CS_F1[31:16]} + {16'h0, CS_F1[15:0]};
    localparam logic [15:0] IP_CSUM = ~CS_F2[15:0];
`else
    localparam logic [15:0] IP_CSUM = 16'h0000;
`endif

    localparam logic [C_S_AXIS_TUSER_WIDTH-1:0] CTL_USER =
        {{(C_S_AXIS_TUSER_WIDTH-16){1'b0}}, 16'd128};

    state_t                           state;
    logic                             last_was_ctl;
    logic                             req_vld;
    logic [11:0]                      req_id;
    logic [3:0]                       req_resv;
    logic [C_S_AXIS_DATA_WIDTH-1:0]   req_data;

    logic                             gnt_ctl;
    logic                             gnt_data;
    logic                             beat1;
    logic                             xfer;
    logic [511:0]                     hdr_be;
    logic [C_S_AXIS_DATA_WIDTH-1:0]   hdr;

    // Header written MSB-first, then byte-swapped so byte 0 sits at tdata[7:0].
    assign hdr_be = {
        DST_MAC, SRC_MAC, 16'h0800,
        16'h4500, 16'h0072, 32'h0, 8'h40, 8'h11, IP_CSUM,
        SRC_IP, DST_IP,
        CTRL_UDP_PORT, CTRL_UDP_PORT, 16'h005e, 16'h0,
        req_id, req_resv, 160'h0
    };

    for (genvar g = 0; g < 64; g++) begin : g_swap
        assign hdr[8*g +: 8] = hdr_be[511-8*g -: 8];
    end

    always_comb begin
        gnt_ctl  = 1'b0;
        gnt_data = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_vld && !last_was_ctl) gnt_ctl = 1'b1;
                else if (s_axis_tvalid)       gnt_data = 1'b1;
                else if (req_vld)             gnt_ctl = 1'b1;
            end
            DATA:       gnt_data = 1'b1;
            CTL0, CTL1: gnt_ctl  = 1'b1;
        endcase
    end

    assign beat1 = (state == CTL1);

    assign m_axis_tvalid = !srst && (gnt_ctl || (gnt_data && s_axis_tvalid));
    assign s_axis_tready = !srst && gnt_data && m_axis_tready;
    assign xfer          = m_axis_tvalid && m_axis_tready;
    // Freeing on the final control beat lets the next request load the same edge.
    assign cfg_ready     = !srst && (!req_vld || (beat1 && m_axis_tready));

    assign m_axis_tdata = gnt_ctl ? (beat1 ? req_data : hdr) : s_axis_tdata;
    assign m_axis_tkeep = gnt_ctl ? '1 : s_axis_tkeep;
    assign m_axis_tuser = gnt_ctl ? CTL_USER : s_axis_tuser;
    assign m_axis_tlast = gnt_ctl ? beat1 : s_axis_tlast;

    always_ff @(posedge clk) begin
        if (srst) begin
            state        <= IDLE;
            last_was_ctl <= 1'b0;
            req_vld      <= 1'b0;
        end else begin
            if (cfg_valid && cfg_ready) begin
                req_vld  <= 1'b1;
                req_id   <= cfg_module_id;
                req_resv <= cfg_resv;
                req_data <= cfg_data;
            end else if (beat1 && xfer) begin
                req_vld <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (gnt_ctl) begin
                        state <= xfer ? CTL1 : CTL0;
                    end else if (gnt_data) begin
                        if (xfer && s_axis_tlast) begin
                            last_was_ctl <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (xfer && s_axis_tlast) begin
                        state        <= IDLE;
                        last_was_ctl <= 1'b0;
                    end
                end
                CTL0: if (xfer) state <= CTL1;
                CTL1: begin
                    if (xfer) begin
                        state        <= IDLE;
                        last_was_ctl <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_pkt_gen.sv
// Directed bench for ctrl_pkt_gen: cycle vector table plus
// backpressure and mid-packet reset sequences.
module tb_ctrl_pkt_gen;

    logic         clk = 1'b0;
    logic         srst = 1'b1;
    logic         cfg_valid = 1'b0;
    logic         cfg_ready;
    logic [11:0]  cfg_module_id = '0;
    logic [3:0]   cfg_resv = '0;
    logic [511:0] cfg_data = '0;
    logic [511:0] s_axis_tdata = '0;
    logic [63:0]  s_axis_tkeep = 64'h0000_0000_ffff_ffff;
    logic [127:0] s_axis_tuser = '0;
    logic         s_axis_tvalid = 1'b0;
    logic         s_axis_tlast = 1'b0;
    logic         s_axis_tready;
    logic [511:0] m_axis_tdata;
    logic [63:0]  m_axis_tkeep;
    logic [127:0] m_axis_tuser;
    logic         m_axis_tvalid;
    logic         m_axis_tlast;
    logic         m_axis_tready = 1'b1;

    int checks = 0;
    int failures = 0;

    ctrl_pkt_gen dut (
        .clk(clk), .srst(srst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_module_id(cfg_module_id), .cfg_resv(cfg_resv),
        .cfg_data(cfg_data),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tuser(s_axis_tuser), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tuser(m_axis_tuser), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           rst;
        bit           cv;
        logic [11:0]  id;
        logic [3:0]   rs;
        logic [511:0] cd;
        bit           sv;
        bit           sl;
        logic [31:0]  tag;
        bit           mr;
        bit           emv;
        bit           eml;
        bit           esr;
        bit           ecr;
        int           kind;
        logic [11:0]  eid;
        logic [3:0]   ers;
        logic [511:0] ecd;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [511:0] act,
                       input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [511:0] exp_hdr(logic [11:0] id, logic [3:0] rs);
        logic [7:0]   b [64];
        logic [511:0] r;
        for (int i = 0; i < 64; i++) b[i] = 8'h00;
        b[12] = 8'h08; b[14] = 8'h45; b[17] = 8'h72;
        b[22] = 8'h40; b[23] = 8'h11;
`ifdef CTRL_IP_CSUM_EN
        b[24] = 8'h66; b[25] = 8'h79;
`endif
        b[26] = 8'h0a; b[29] = 8'h01; b[30] = 8'h0a; b[33] = 8'h02;
        b[34] = 8'hf1; b[35] = 8'hf2; b[36] = 8'hf1; b[37] = 8'hf2;
        b[39] = 8'h5e;
        b[42] = id[11:4];
        b[43] = {id[3:0], rs};
        for (int i = 0; i < 64; i++) r[8*i +: 8] = b[i];
        return r;
    endfunction

    function automatic logic [511:0] dpat(logic [31:0] k);
        return {16{32'h1111_0000 | k}};
    endfunction

    function automatic vec_t mk(
        bit rst, bit cv, logic [11:0] id, logic [3:0] rs, logic [511:0] cd,
        bit sv, bit sl, logic [31:0] tag, bit mr,
        bit emv, bit eml, bit esr, bit ecr,
        int kind, logic [11:0] eid, logic [3:0] ers, logic [511:0] ecd);
        vec_t v;
        v.rst = rst; v.cv = cv; v.id = id; v.rs = rs; v.cd = cd;
        v.sv = sv; v.sl = sl; v.tag = tag; v.mr = mr;
        v.emv = emv; v.eml = eml; v.esr = esr; v.ecr = ecr;
        v.kind = kind; v.eid = eid; v.ers = ers; v.ecd = ecd;
        return v;
    endfunction

    logic [511:0] da, d2, d3, d4, d5, d6, d9;
    logic [511:0] edat;
    logic [127:0] euser;
    logic [63:0]  ekeep;
    int           nx;

    initial begin
        da = {16{32'ha5a5_a5a5}};
        d2 = dpat(2); d3 = dpat(3); d4 = dpat(4);
        d5 = dpat(5); d6 = dpat(6); d9 = dpat(9);

        // reset, single request, back-to-back request
        tbl.push_back(mk(1,1,12'h012,4'h3,da, 1,0,32'hd0,1, 0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(0,1,12'h012,4'h3,da, 0,0,32'h0,1,  0,0,0,1, 0,0,0,0));
        tbl.push_back(mk(0,0,12'h0,4'h0,0,    0,0,32'h0,1,  1,0,0,0, 2,12'h012,4'h3,0));
        tbl.push_back(mk(0,1,12'h345,4'ha,d2, 0,0,32'h0,1,  1,1,0,1, 3,0,0,da));
        tbl.push_back(mk(0,0,12'h0,4'h0,0,    0,0,32'h0,1,  1,0,0,0, 2,12'h345,4'ha,0));
        tbl.push_back(mk(0,0,12'h0,4'h0,0,    0,0,32'h0,1,  1,1,0,1, 3,0,0,d2));
        // request raised mid data packet
        tbl.push_back(mk(0,0,12'h0,4'h0,0,    1,0,32'hd0,1, 1,0,1,1, 1,0,0,0));
        tbl.push_back(mk(0,1,12'h678,4'h5,d3, 1,0,32'hd1,1, 1,0,1,1, 1,0,0,0));
        tbl.push_back(mk(0,0,12'h0,4'h0,0,    1,0,32'hd2,1, 1,0,1,0, 1,0,0,0));
        tbl.push_back(mk(0,0,12'h0,4'h0,0,    1,1,32'hd3,1, 1,1,1,0, 1,0,0,0));
        tbl.push_back(mk(0,0,12'h0,4'h0,0,    0,0,32'h0,1,  1,0,0,0, 2,12'h678,4'h5,0));
        tbl.push_back(mk(0,0,12'h0,4'h0,0,    0,0,32'h0,1,  1,1,0,1, 3,0,0,d3));
        // alternation with data continuously valid
        tbl.push_back(mk(1,1,12'h0,4'h0,0,    1,0,32'he0,1, 0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(0,1,12'h111,4'h1,d4, 0,0,32'h0,1,  0,0,0,1, 0,0,0,0));
        tbl.push_back(mk(0,1,12'h222,4'h2,d5, 1,0,32'he0,1, 1,0,0,0, 2,12'h111,4'h1,0));
        tbl.push_back(mk(0,1,12'h222,4'h2,d5, 1,0,32'he0,1, 1,1,0,1, 3,0,0,d4));
        tbl.push_back(mk(0,1,12'h333,4'h3,d6, 1,0,32'he0,1, 1,0,1,0, 1,0,0,0));
        tbl.push_back(mk(0,1,12'h333,4'h3,d6, 1,1,32'he1,1, 1,1,1,0, 1,0,0,0));
        tbl.push_back(mk(0,1,12'h333,4'h3,d6, 1,0,32'he2,1, 1,0,0,0, 2,12'h222,4'h2,0));
        tbl.push_back(mk(0,1,12'h333,4'h3,d6, 1,0,32'he2,1, 1,1,0,1, 3,0,0,d5));
        tbl.push_back(mk(0,0,12'h0,4'h0,0,    1,0,32'he2,1, 1,0,1,0, 1,0,0,0));
        tbl.push_back(mk(0,0,12'h0,4'h0,0,    1,1,32'he3,1, 1,1,1,0, 1,0,0,0));
        tbl.push_back(mk(0,0,12'h0,4'h0,0,    1,0,32'he4,1, 1,0,0,0, 2,12'h333,4'h3,0));
        tbl.push_back(mk(0,0,12'h0,4'h0,0,    1,0,32'he4,1, 1,1,0,1, 3,0,0,d6));
        tbl.push_back(mk(0,0,12'h0,4'h0,0,    0,0,32'h0,1,  0,0,0,1, 0,0,0,0));

        repeat (2) @(negedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            srst          = tbl[i].rst;
            cfg_valid     = tbl[i].cv;
            cfg_module_id = tbl[i].id;
            cfg_resv      = tbl[i].rs;
            cfg_data      = tbl[i].cd;
            s_axis_tvalid = tbl[i].sv;
            s_axis_tlast  = tbl[i].sl;
            s_axis_tdata  = {16{tbl[i].tag}};
            s_axis_tuser  = {96'h0, tbl[i].tag};
            m_axis_tready = tbl[i].mr;
            #1;
            chk($sformatf("v%0d_mvalid", i), 512'(m_axis_tvalid), 512'(tbl[i].emv));
            chk($sformatf("v%0d_sready", i), 512'(s_axis_tready), 512'(tbl[i].esr));
            chk($sformatf("v%0d_cready", i), 512'(cfg_ready), 512'(tbl[i].ecr));
            if (tbl[i].emv) begin
                if (tbl[i].kind == 1) begin
                    edat  = {16{tbl[i].tag}};
                    euser = {96'h0, tbl[i].tag};
                    ekeep = 64'h0000_0000_ffff_ffff;
                end else begin
                    edat  = (tbl[i].kind == 2) ?
                            exp_hdr(tbl[i].eid, tbl[i].ers) : tbl[i].ecd;
                    euser = 128'd128;
                    ekeep = '1;
                end
                chk($sformatf("v%0d_tlast", i), 512'(m_axis_tlast), 512'(tbl[i].eml));
                chk($sformatf("v%0d_tdata", i), m_axis_tdata, edat);
                chk($sformatf("v%0d_tuser", i), 512'(m_axis_tuser), 512'(euser));
                chk($sformatf("v%0d_tkeep", i), 512'(m_axis_tkeep), 512'(ekeep));
            end
        end

        // backpressure toggling during a control packet
        @(negedge clk);
        cfg_valid = 1'b1; cfg_module_id = 12'h012; cfg_resv = 4'h3;
        cfg_data = da; s_axis_tvalid = 1'b0; m_axis_tready = 1'b0;
        #1 chk("bp_cready", 512'(cfg_ready), 512'(1'b1));
        nx = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            cfg_valid = 1'b0;
            m_axis_tready = (k % 2 == 1);
            #1;
            chk($sformatf("bp%0d_mvalid", k), 512'(m_axis_tvalid), 512'(nx < 2));
            if (m_axis_tvalid) begin
                chk($sformatf("bp%0d_tdata", k), m_axis_tdata,
                    (nx == 0) ? exp_hdr(12'h012, 4'h3) : da);
                chk($sformatf("bp%0d_tlast", k), 512'(m_axis_tlast), 512'(nx == 1));
                if (k == 0) begin
                    chk("byte42", 512'(m_axis_tdata[42*8 +: 8]), 512'(8'h01));
                    chk("byte43", 512'(m_axis_tdata[43*8 +: 8]), 512'(8'h23));
                    chk("byte23", 512'(m_axis_tdata[23*8 +: 8]), 512'(8'h11));
`ifdef CTRL_IP_CSUM_EN
                    chk("byte24", 512'(m_axis_tdata[24*8 +: 8]), 512'(8'h66));
                    chk("byte25", 512'(m_axis_tdata[25*8 +: 8]), 512'(8'h79));
`else
                    chk("byte24", 512'(m_axis_tdata[24*8 +: 8]), 512'(8'h00));
                    chk("byte25", 512'(m_axis_tdata[25*8 +: 8]), 512'(8'h00));
`endif
                    chk("tuser_len", 512'(m_axis_tuser[15:0]), 512'(16'd128));
                end
                if (m_axis_tready) nx++;
            end
        end
        chk("bp_beats", 512'(nx), 512'(2));

        // reset while the second control beat is stalled
        @(negedge clk);
        cfg_valid = 1'b1; cfg_module_id = 12'h5a5; cfg_resv = 4'h6;
        cfg_data = d9; m_axis_tready = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        #1 chk("rs_beat0", 512'(m_axis_tvalid), 512'(1'b1));
        @(negedge clk);
        m_axis_tready = 1'b0;
        #1 chk("rs_ctl1_last", 512'(m_axis_tvalid && m_axis_tlast), 512'(1'b1));
        srst = 1'b1;
        #1 chk("rs_mvalid_in_rst", 512'(m_axis_tvalid), 512'(1'b0));
        chk("rs_cready_in_rst", 512'(cfg_ready), 512'(1'b0));
        @(negedge clk);
        srst = 1'b0; m_axis_tready = 1'b1;
        #1 chk("rs_mvalid_after", 512'(m_axis_tvalid), 512'(1'b0));
        chk("rs_cready_after", 512'(cfg_ready), 512'(1'b1));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1 chk($sformatf("rs_stale%0d", k), 512'(m_axis_tvalid), 512'(1'b0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ctrl_pkt_gen.md
# ctrl_pkt_gen

Control-packet transmitter and stream merger at the ingress of the RMT pipeline, ahead of `pkt_filter`. It builds one 2-beat UDP/IPv4 control packet per table-write request and merges it into the data AXI-Stream at packet boundaries. `pkt_filter` then diverts it onto the parser/stage control chain. It is the sending end of the in-band reconfiguration protocol.

## Interface
- C_S_AXIS_DATA_WIDTH, 512, stream width; only 512 is supported.
- C_S_AXIS_TUSER_WIDTH, 128, tuser width.
- CTRL_UDP_PORT, 16'hf1f2, UDP src/dst port marking control packets.
- SRC_MAC / DST_MAC, 48'h0, Ethernet addresses.
- SRC_IP / DST_IP, 32'h0a000001 / 32'h0a000002, IPv4 addresses.

Ports:
- clk  in  1  stream clock; the only clock.
- srst  in  1  synchronous, active-high reset.
- cfg_valid / cfg_ready  in / out  1 / 1  write-request handshake.
- cfg_module_id  in  12  target parser/stage/deparser id.
- cfg_resv  in  4  entry-type selector.
- cfg_data  in  512  entry payload.
- s_axis_tdata/tkeep/tuser/tvalid/tlast  in  512/64/128/1/1  data stream in.
- s_axis_tready  out  1.
- m_axis_tdata/tkeep/tuser/tvalid/tlast  out  512/64/128/1/1  merged stream out.
- m_axis_tready  in  1.

## Operation
- Request register: one entry holding {module_id, resv, data}.
  - cfg_ready = register empty.
  - Loads on cfg_valid & cfg_ready.
  - Frees on acceptance of control beat 1.
- FSM states: IDLE, DATA, CTL0, CTL1.
- IDLE, grant rule:
  - Pending request with last_was_ctl=0 → CTL0.
  - Otherwise, s_axis_tvalid → data grant.
  - Otherwise, pending request → CTL0.
  - This alternation prevents starvation of either source.
- Data grant (IDLE or DATA):
  - m_axis_* = s_axis_* combinationally; s_axis_tready = m_axis_tready.
  - An accepted beat with tlast=0 → DATA.
  - An accepted beat with tlast=1 → IDLE, last_was_ctl←0.
  - DATA stays until the tlast beat is accepted.
- CTL0 / CTL1 outputs:
  - m_axis_tvalid=1, s_axis_tready=0.
  - Beat accepted: CTL0→CTL1; CTL1→IDLE, last_was_ctl←1.
- Byte n of a beat = tdata[8n+7:8n]; multi-byte header fields are big-endian.
- Beat 0 (tkeep all ones, tlast 0):
  - Bytes 0-5: DST_MAC. Bytes 6-11: SRC_MAC. Bytes 12-13: 0x0800.
  - Bytes 14-15: 0x4500. Bytes 16-17: IP total length 0x0072. Bytes 18-21: 0.
  - Byte 22: TTL 0x40. Byte 23: protocol 0x11. Bytes 24-25: IP checksum.
  - Bytes 26-29: SRC_IP. Bytes 30-33: DST_IP.
  - Bytes 34-37: CTRL_UDP_PORT twice (src, dst). Bytes 38-39: UDP length 0x005e. Bytes 40-41: 0.
  - Bytes 42-43: {module_id, resv}, with byte 42 = module_id[11:4].
  - Bytes 44-63: 0.
- Beat 1 (tkeep all ones, tlast 1): tdata = cfg_data.
- Control tuser, both beats: [15:0] = 128 (packet bytes); all other bits 0.
- Control output fields are driven from the request register only, so they are stable while m_axis_tvalid=1 and m_axis_tready=0.

## Timing
- Reset values: m_axis_tvalid 0, s_axis_tready 0, cfg_ready 0 during reset; cfg_ready 1 from the first cycle after reset.
- Register state after reset: FSM=IDLE, last_was_ctl=0, register empty.
- Request accepted at edge N, FSM in IDLE, no data contention → beat 0 valid in cycle N+1, beat 1 in N+2 if m_axis_tready=1.
- Data path: zero-latency combinational passthrough.
- Back-to-back requests:
  - The next request is accepted in the same cycle beat 1 completes (cfg_ready is 0 until then; the register is freed at that edge).
  - Peak rate: 1 control packet per 2 cycles when no data is present.
- A request arriving mid data packet waits for that packet's tlast; it never splits a packet.
- A reset during CTL0/CTL1 or DATA drops the in-flight packet and the request register contents; the FSM restarts in IDLE.

## Configuration
- CTRL_IP_CSUM_EN defined: bytes 24-25 carry the IPv4 header checksum.
  - Checksum = ~(16-bit one's-complement sum of the 10 header words, with the checksum word taken as 0; carries folded twice).
  - Derived from parameters only.
- Undefined: bytes 24-25 = 0x0000.

## Test plan
- Reset and idle: after reset, request {id=0x012, resv=0x3, data=512'hA5…A5} with m_axis_tready=1.
  - Beat 0 in cycle N+1, beat 1 in N+2.
  - Bytes 42-43 = 0x01,0x23; byte 23 = 0x11; tuser[15:0] = 128.
- Checksum, default IPs: with CTRL_IP_CSUM_EN, bytes 24-25 = 0x66,0x79. Without it, bytes 24-25 = 0x00,0x00.
- Mid-packet request: 4-beat data packet, request raised on beat 1.
  - All 4 data beats are output contiguously, then the control packet.
  - No control beat is interleaved.
- Alternation: data packets continuously valid, 3 requests queued.
  - Output order: ctl, data, ctl, data, ctl.
  - cfg_ready deasserts while the register is occupied.
- Backpressure: m_axis_tready toggled 1010… during the control packet → beats hold stable and exactly 2 beats are transferred.
- Reset mid-CTL1: srst pulses while in CTL1 → m_axis_tvalid=0 next cycle, cfg_ready=1 after release, no stale beat output.
